// File: rtl/ctrl_seq.sv
// ============================================================================
// Module      : ctrl_seq
// Description : Multicycle-core control sequencer with request handshakes,
//               error traps, per-state watchdog and stale-response dropping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_seq #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int STALE_MAX      = 3,
    parameter int EXEC_EN        = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ifu_reqReady,
    input  logic       ifu_respValid,
    input  logic       ifu_respErr,
    input  logic       lsu_reqReady,
    input  logic       lsu_respValid,
    input  logic       lsu_respErr,
    input  logic       is_load,
    input  logic       is_store,
    input  logic       is_multi,
    input  logic       exec_done,
    input  logic       trap_clear,
    output logic       ifu_reqValid,
    output logic       lsu_reqValid,
    output logic       lsu_wen,
    output logic       pc_wen,
    output logic       reg_wen,
    output logic       exec_start,
    output logic       trap,
    output logic [1:0] trap_cause
);

    localparam logic [2:0] c_ST_START = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_MEM   = 3'd2;
    localparam logic [2:0] c_ST_EXEC  = 3'd3;
    localparam logic [2:0] c_ST_TRAP  = 3'd4;

    localparam logic [1:0] c_CAUSE_NONE = 2'd0;
    localparam logic [1:0] c_CAUSE_IFU  = 2'd1;
    localparam logic [1:0] c_CAUSE_LSU  = 2'd2;
    localparam logic [1:0] c_CAUSE_TMO  = 2'd3;

    localparam bit c_WDT_ON  = (TIMEOUT_CYCLES > 0);
    localparam bit c_EXEC_ON = (EXEC_EN != 0);
    localparam int c_WDT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_STL_W   = (STALE_MAX > 0) ? $clog2(STALE_MAX + 1) : 1;
    localparam int c_WDT_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [c_WDT_W-1:0] c_WDT_LAST = c_WDT_W'(c_WDT_LAST_I);
    localparam logic [c_STL_W-1:0] c_STL_MAX  = c_STL_W'(STALE_MAX);

    logic [2:0]         r_state;
    logic [1:0]         r_cause;
    logic               r_ifu_acc;
    logic               r_lsu_acc;
    logic               r_is_load;
    logic               r_is_store;
    logic [c_WDT_W-1:0] r_wdt;
    logic [c_STL_W-1:0] r_ifu_stale;
    logic [c_STL_W-1:0] r_lsu_stale;

    logic       w_in_fetch;
    logic       w_in_mem;
    logic       w_in_exec;
    logic       w_waiting;
    logic       w_ifu_req;
    logic       w_lsu_req;
    logic       w_ifu_accept;
    logic       w_lsu_accept;
    logic       w_ifu_drop;
    logic       w_lsu_drop;
    logic       w_ifu_resp;
    logic       w_lsu_resp;
    logic       w_exec_fin;
    logic       w_complete;
    logic       w_timeout;
    logic       w_ifu_inc;
    logic       w_lsu_inc;
    logic       w_trans;
    logic [2:0] w_next;
    logic [1:0] w_cause_nxt;
    logic       w_pc_wen;
    logic       w_reg_wen;
    logic       w_exec_start;

    assign w_in_fetch = (r_state == c_ST_FETCH);
    assign w_in_mem   = (r_state == c_ST_MEM);
    assign w_in_exec  = (r_state == c_ST_EXEC);
    assign w_waiting  = w_in_fetch | w_in_mem | w_in_exec;

    assign w_ifu_req    = w_in_fetch & ~r_ifu_acc;
    assign w_lsu_req    = w_in_mem & ~r_lsu_acc;
    assign w_ifu_accept = w_ifu_req & ifu_reqReady;
    assign w_lsu_accept = w_lsu_req & lsu_reqReady;

    // Responses owed to an abandoned request are swallowed before anything else sees them.
    assign w_ifu_drop = ifu_respValid & (r_ifu_stale != '0);
    assign w_lsu_drop = lsu_respValid & (r_lsu_stale != '0);
    assign w_ifu_resp = w_in_fetch & r_ifu_acc & (r_ifu_stale == '0) & ifu_respValid;
    assign w_lsu_resp = w_in_mem & r_lsu_acc & (r_lsu_stale == '0) & lsu_respValid;
    assign w_exec_fin = w_in_exec & exec_done;

    assign w_complete = w_ifu_resp | w_lsu_resp | w_exec_fin;
    assign w_timeout  = c_WDT_ON & w_waiting & (r_wdt == c_WDT_LAST) & ~w_complete;

    assign w_ifu_inc = w_timeout & w_in_fetch & (r_ifu_acc | w_ifu_accept);
    assign w_lsu_inc = w_timeout & w_in_mem & (r_lsu_acc | w_lsu_accept);

    always_comb begin
        w_next       = r_state;
        w_cause_nxt  = r_cause;
        w_pc_wen     = 1'b0;
        w_reg_wen    = 1'b0;
        w_exec_start = 1'b0;
        case (r_state)
            c_ST_START: begin
                w_next = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                if (w_ifu_resp) begin
                    if (ifu_respErr) begin
                        w_next      = c_ST_TRAP;
                        w_cause_nxt = c_CAUSE_IFU;
                    end else begin
                        w_pc_wen = 1'b1;
                        if (is_load | is_store) begin
                            w_next = c_ST_MEM;
                        end else if (is_multi & c_EXEC_ON) begin
                            w_next       = c_ST_EXEC;
                            w_exec_start = 1'b1;
                        end else begin
                            w_reg_wen = 1'b1;
                        end
                    end
                end else if (w_timeout) begin
                    w_next      = c_ST_TRAP;
                    w_cause_nxt = c_CAUSE_TMO;
                end
            end
            c_ST_MEM: begin
                if (w_lsu_resp) begin
                    if (lsu_respErr) begin
                        w_next      = c_ST_TRAP;
                        w_cause_nxt = c_CAUSE_LSU;
                    end else begin
                        w_reg_wen = r_is_load;
                        w_next    = c_ST_FETCH;
                    end
                end else if (w_timeout) begin
                    w_next      = c_ST_TRAP;
                    w_cause_nxt = c_CAUSE_TMO;
                end
            end
            c_ST_EXEC: begin
                if (w_exec_fin) begin
                    w_reg_wen = 1'b1;
                    w_next    = c_ST_FETCH;
                end else if (w_timeout) begin
                    w_next      = c_ST_TRAP;
                    w_cause_nxt = c_CAUSE_TMO;
                end
            end
            c_ST_TRAP: begin
                if (trap_clear) begin
                    w_next      = c_ST_FETCH;
                    w_cause_nxt = c_CAUSE_NONE;
                end
            end
            default: begin
                w_next      = c_ST_START;
                w_cause_nxt = c_CAUSE_NONE;
            end
        endcase
    end

    // A completed fetch always restarts the fetch state, even when it loops back to itself.
    assign w_trans = (w_next != r_state) | w_ifu_resp;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= c_ST_START;
            r_cause     <= c_CAUSE_NONE;
            r_ifu_acc   <= 1'b0;
            r_lsu_acc   <= 1'b0;
            r_is_load   <= 1'b0;
            r_is_store  <= 1'b0;
            r_wdt       <= '0;
            r_ifu_stale <= '0;
            r_lsu_stale <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause_nxt;

            if (w_trans || !w_waiting) begin
                r_wdt <= '0;
            end else begin
                r_wdt <= r_wdt + 1'b1;
            end

            if (w_trans) begin
                r_ifu_acc <= 1'b0;
                r_lsu_acc <= 1'b0;
            end else begin
                if (w_ifu_accept) r_ifu_acc <= 1'b1;
                if (w_lsu_accept) r_lsu_acc <= 1'b1;
            end

            if (w_ifu_resp && !ifu_respErr) begin
                r_is_store <= is_store;
                r_is_load  <= is_load & ~is_store;
            end

            if (w_ifu_inc && !w_ifu_drop) begin
                if (r_ifu_stale != c_STL_MAX) r_ifu_stale <= r_ifu_stale + 1'b1;
            end else if (w_ifu_drop && !w_ifu_inc) begin
                r_ifu_stale <= r_ifu_stale - 1'b1;
            end

            if (w_lsu_inc && !w_lsu_drop) begin
                if (r_lsu_stale != c_STL_MAX) r_lsu_stale <= r_lsu_stale + 1'b1;
            end else if (w_lsu_drop && !w_lsu_inc) begin
                r_lsu_stale <= r_lsu_stale - 1'b1;
            end
        end
    end

    // Outputs are forced low whenever reset is asserted, before the reset edge lands.
    assign ifu_reqValid = reset_n & w_ifu_req;
    assign lsu_reqValid = reset_n & w_lsu_req;
    assign lsu_wen      = reset_n & w_lsu_req & r_is_store;
    assign pc_wen       = reset_n & w_pc_wen;
    assign reg_wen      = reset_n & w_reg_wen;
    assign exec_start   = reset_n & w_exec_start;
    assign trap         = reset_n & (r_state == c_ST_TRAP);
    assign trap_cause   = reset_n ? r_cause : c_CAUSE_NONE;

endmodule

`default_nettype wire
